// File: rtl/fetch_buf_ctrl.sv
// Fetch-packet queue between IF and ID: circular buffer of paired-instruction packets
// with an issue FSM that stalls on ibar drains and halts on exceptions until flush.
module fetch_buf_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_inst0,
    input  logic [31:0]      if_inst1,
    input  logic [31:0]      if_pc,
    input  logic [6:0]       if_exception,
    input  logic [1:0]       if_excp_flag,
    input  logic [1:0]       if_ibar_flag,
    input  logic             id_allowin,
    output logic             fifo_readygo,
    output logic [31:0]      fifo_inst0,
    output logic [31:0]      fifo_inst1,
    output logic [31:0]      fifo_pc,
    output logic [31:0]      fifo_pcAdd,
    output logic [31:0]      fifo_pc_next,
    output logic [6:0]       fifo_exception,
    output logic [1:0]       fifo_excp_flag,
    output logic [1:0]       fifo_ibar_flag,
    input  logic             ibar_done,
    output logic             ibar_wait,
    output logic             excp_halt,
    output logic             fetch_buf_empty,
    output logic             fetch_buf_full,
    output logic [PTR_W:0]   fetch_buf_count
);

    localparam logic [31:0] INST_NOP = 32'h0340_0000;
    localparam logic [31:0] PC_RESET = 32'h1C00_0000;
    localparam int          PKT_W    = 107;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IBAR_WAIT = 2'd1,
        EXCP_HALT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [PKT_W-1:0]   mem_q [DEPTH];

    logic [PKT_W-1:0]   if_pkt;
    logic [PKT_W-1:0]   head_pkt;
    logic               push;
    logic               pop;

    // Packet layout: {inst0, inst1, pc, exception, excp_flag, ibar_flag}
    assign if_pkt   = {if_inst0, if_inst1, if_pc, if_exception, if_excp_flag, if_ibar_flag};
    assign head_pkt = mem_q[head_q];

    assign fetch_buf_count = count_q;
    assign fetch_buf_empty = (count_q == '0);
    assign fetch_buf_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign if_ready        = !fetch_buf_full && !flush;
    assign fifo_readygo    = !fetch_buf_empty && (state_q == RUN) && !flush;
    assign push            = if_valid && if_ready;
    assign pop             = fifo_readygo && id_allowin;
    assign ibar_wait       = (state_q == IBAR_WAIT);
    assign excp_halt       = (state_q == EXCP_HALT);

    always_comb begin
        fifo_inst0     = INST_NOP;
        fifo_inst1     = INST_NOP;
        fifo_pc        = PC_RESET;
        fifo_exception = '0;
        fifo_excp_flag = '0;
        fifo_ibar_flag = '0;
        if (fifo_readygo) begin
            {fifo_inst0, fifo_inst1, fifo_pc, fifo_exception,
             fifo_excp_flag, fifo_ibar_flag} = head_pkt;
        end
        fifo_pcAdd   = fifo_pc + 32'd4;
        fifo_pc_next = fifo_pc + 32'd8;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = RUN;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            unique case (state_q)
                RUN: begin
                    // ibar takes precedence when a packet carries both markers
                    if (pop && (fifo_ibar_flag != '0))      state_d = IBAR_WAIT;
                    else if (pop && (fifo_excp_flag != '0)) state_d = EXCP_HALT;
                end
                IBAR_WAIT: if (ibar_done) state_d = RUN;
                EXCP_HALT: state_d = EXCP_HALT;
                default:   state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= if_pkt;
    end

endmodule

// File: tb/tb_fetch_buf_ctrl.sv
// Directed bench for fetch_buf_ctrl: issue latency, full/empty limits, ibar wait,
// exception halt, flush priority, async reset and PC arithmetic wrap.
module tb_fetch_buf_ctrl;

    localparam logic [31:0] NOP  = 32'h0340_0000;
    localparam logic [31:0] PCR  = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rstn, flush, if_valid, id_allowin, ibar_done;
    logic [31:0] if_inst0, if_inst1, if_pc;
    logic [6:0]  if_exception;
    logic [1:0]  if_excp_flag, if_ibar_flag;
    logic        if_ready, fifo_readygo, ibar_wait, excp_halt;
    logic [31:0] fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next;
    logic [6:0]  fifo_exception;
    logic [1:0]  fifo_excp_flag, fifo_ibar_flag;
    logic        fetch_buf_empty, fetch_buf_full;
    logic [3:0]  fetch_buf_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_buf_ctrl #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_inst0(if_inst0), .if_inst1(if_inst1), .if_pc(if_pc),
        .if_exception(if_exception), .if_excp_flag(if_excp_flag), .if_ibar_flag(if_ibar_flag),
        .id_allowin(id_allowin), .fifo_readygo(fifo_readygo),
        .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1), .fifo_pc(fifo_pc),
        .fifo_pcAdd(fifo_pcAdd), .fifo_pc_next(fifo_pc_next),
        .fifo_exception(fifo_exception), .fifo_excp_flag(fifo_excp_flag),
        .fifo_ibar_flag(fifo_ibar_flag),
        .ibar_done(ibar_done), .ibar_wait(ibar_wait), .excp_halt(excp_halt),
        .fetch_buf_empty(fetch_buf_empty), .fetch_buf_full(fetch_buf_full),
        .fetch_buf_count(fetch_buf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pkt(input logic [31:0] pc, input logic [1:0] ef, input logic [1:0] bf,
                             input logic [6:0] ex);
        if_valid     = 1'b1;
        if_pc        = pc;
        if_inst0     = pc ^ 32'hA5A5_0000;
        if_inst1     = pc ^ 32'h5A5A_0000;
        if_excp_flag = ef;
        if_ibar_flag = bf;
        if_exception = ex;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        rstn = 1'b0; flush = 1'b0; if_valid = 1'b0; id_allowin = 1'b0; ibar_done = 1'b0;
        if_inst0 = '0; if_inst1 = '0; if_pc = '0; if_exception = '0;
        if_excp_flag = '0; if_ibar_flag = '0;
        #1;
        // reset state
        chk("rst_empty",   32'(fetch_buf_empty), 32'd1);
        chk("rst_full",    32'(fetch_buf_full),  32'd0);
        chk("rst_count",   32'(fetch_buf_count), 32'd0);
        chk("rst_ready",   32'(if_ready),        32'd1);
        chk("rst_readygo", 32'(fifo_readygo),    32'd0);
        chk("rst_inst0",   fifo_inst0,           NOP);
        chk("rst_inst1",   fifo_inst1,           NOP);
        chk("rst_pc",      fifo_pc,              PCR);
        chk("rst_pcadd",   fifo_pcAdd,           32'h1C00_0004);
        chk("rst_pcnext",  fifo_pc_next,         32'h1C00_0008);
        chk("rst_ibw",     32'(ibar_wait),       32'd0);
        chk("rst_halt",    32'(excp_halt),       32'd0);
        step(); step();
        rstn = 1'b1;

        // single packet, one-cycle issue latency
        id_allowin = 1'b1;
        drive_pkt(32'h1C00_0000, 2'b00, 2'b00, 7'h00);
        step();
        if_valid = 1'b0;
        chk("t1_readygo", 32'(fifo_readygo), 32'd1);
        chk("t1_pc",      fifo_pc,           32'h1C00_0000);
        chk("t1_pcadd",   fifo_pcAdd,        32'h1C00_0004);
        chk("t1_pcnext",  fifo_pc_next,      32'h1C00_0008);
        chk("t1_inst0",   fifo_inst0,        32'hB9A5_0000);
        chk("t1_inst1",   fifo_inst1,        32'h465A_0000);
        step();
        chk("t1_empty",   32'(fetch_buf_empty), 32'd1);
        chk("t1_nop",     fifo_inst0,           NOP);

        // fill to full, overflow attempt, then simultaneous push/pop at 7
        id_allowin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_pkt(32'h200 + 32'(i) * 8, 2'b00, 2'b00, 7'h00);
            step();
        end
        chk("t2_count8",  32'(fetch_buf_count), 32'd8);
        chk("t2_full",    32'(fetch_buf_full),  32'd1);
        chk("t2_ready",   32'(if_ready),        32'd0);
        drive_pkt(32'hDEAD_0000, 2'b00, 2'b00, 7'h00);
        step();
        chk("t2_ovf_cnt", 32'(fetch_buf_count), 32'd8);
        chk("t2_head",    fifo_pc,              32'h200);
        if_valid = 1'b0; id_allowin = 1'b1;
        step();
        chk("t2_count7",  32'(fetch_buf_count), 32'd7);
        chk("t2_head2",   fifo_pc,              32'h208);
        drive_pkt(32'h300, 2'b00, 2'b00, 7'h00);
        step();
        chk("t2_pp_cnt",  32'(fetch_buf_count), 32'd7);
        chk("t2_head3",   fifo_pc,              32'h210);
        if_valid = 1'b0; id_allowin = 1'b0; flush = 1'b1;
        #1;
        chk("t2_fl_rdy",  32'(if_ready),     32'd0);
        chk("t2_fl_rgo",  32'(fifo_readygo), 32'd0);
        step();
        flush = 1'b0;
        chk("t2_fl_cnt",  32'(fetch_buf_count), 32'd0);

        // ibar stall
        drive_pkt(32'h100, 2'b00, 2'b00, 7'h00); step();
        drive_pkt(32'h108, 2'b00, 2'b01, 7'h00); step();
        drive_pkt(32'h110, 2'b00, 2'b00, 7'h00); step();
        if_valid = 1'b0; id_allowin = 1'b1;
        chk("t3_count3",  32'(fetch_buf_count), 32'd3);
        chk("t3_head0",   fifo_pc,              32'h100);
        step();
        chk("t3_head1",   fifo_pc,              32'h108);
        chk("t3_ibflag",  32'(fifo_ibar_flag),  32'd1);
        step();
        chk("t3_ibw",     32'(ibar_wait),       32'd1);
        chk("t3_rgo0",    32'(fifo_readygo),    32'd0);
        chk("t3_cnt1",    32'(fetch_buf_count), 32'd1);
        chk("t3_maskpc",  fifo_pc,              PCR);
        step();
        chk("t3_ibw_hold", 32'(ibar_wait),       32'd1);
        chk("t3_cnt_hold", 32'(fetch_buf_count), 32'd1);
        ibar_done = 1'b1;
        step();
        ibar_done = 1'b0;
        chk("t3_ibw_clr", 32'(ibar_wait),    32'd0);
        chk("t3_rgo1",    32'(fifo_readygo), 32'd1);
        chk("t3_head2",   fifo_pc,           32'h110);
        step();
        chk("t3_empty",   32'(fetch_buf_empty), 32'd1);

        // exception halt until flush
        id_allowin = 1'b0;
        drive_pkt(32'h400, 2'b10, 2'b00, 7'h15); step();
        drive_pkt(32'h408, 2'b00, 2'b00, 7'h00); step();
        drive_pkt(32'h410, 2'b00, 2'b00, 7'h00); step();
        drive_pkt(32'h418, 2'b00, 2'b00, 7'h00); step();
        if_valid = 1'b0; id_allowin = 1'b1;
        chk("t4_exc",     32'(fifo_exception), 32'h15);
        chk("t4_eflag",   32'(fifo_excp_flag), 32'd2);
        step();
        chk("t4_halt",    32'(excp_halt),       32'd1);
        chk("t4_cnt3",    32'(fetch_buf_count), 32'd3);
        chk("t4_rgo0",    32'(fifo_readygo),    32'd0);
        drive_pkt(32'h420, 2'b00, 2'b00, 7'h00);
        chk("t4_rdy",     32'(if_ready),        32'd1);
        step();
        if_valid = 1'b0;
        chk("t4_cnt4",    32'(fetch_buf_count), 32'd4);
        ibar_done = 1'b1;
        step();
        ibar_done = 1'b0;
        chk("t4_halt2",   32'(excp_halt),       32'd1);
        chk("t4_cnt4b",   32'(fetch_buf_count), 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_fl_cnt",  32'(fetch_buf_count), 32'd0);
        chk("t4_fl_halt", 32'(excp_halt),       32'd0);
        chk("t4_fl_rgo",  32'(fifo_readygo),    32'd0);

        // flush beats same-cycle push and pop
        id_allowin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_pkt(32'h500 + 32'(i) * 8, 2'b00, 2'b00, 7'h00);
            step();
        end
        chk("t5_cnt4",    32'(fetch_buf_count), 32'd4);
        drive_pkt(32'h5F0, 2'b00, 2'b00, 7'h00);
        flush = 1'b1; id_allowin = 1'b1;
        step();
        flush = 1'b0; id_allowin = 1'b0;
        drive_pkt(32'h600, 2'b00, 2'b00, 7'h00);
        chk("t5_cnt0",    32'(fetch_buf_count), 32'd0);
        chk("t5_empty",   32'(fetch_buf_empty), 32'd1);
        step();
        chk("t5_head",    fifo_pc,              32'h600);
        chk("t5_cnt1",    32'(fetch_buf_count), 32'd1);
        drive_pkt(32'h608, 2'b00, 2'b00, 7'h00);
        step();
        if_valid = 1'b0;
        chk("t5_cnt2",    32'(fetch_buf_count), 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_arst_emp", 32'(fetch_buf_empty), 32'd1);
        chk("t5_arst_cnt", 32'(fetch_buf_count), 32'd0);
        chk("t5_arst_rgo", 32'(fifo_readygo),    32'd0);
        step();
        rstn = 1'b1;

        // pc arithmetic wraps at 2^32
        drive_pkt(32'hFFFF_FFFC, 2'b00, 2'b00, 7'h00);
        step();
        if_valid = 1'b0;
        chk("t6_pc",      fifo_pc,      32'hFFFF_FFFC);
        chk("t6_pcadd",   fifo_pcAdd,   32'h0000_0000);
        chk("t6_pcnext",  fifo_pc_next, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
